// File: rtl/pool_channel_scheduler.sv
// Round-robin scheduler sharing one 6x6 max-pool engine across conv channels.
// Muxes the granted tile, bounds the engine wait, returns a tagged 3x3 result.
module pool_channel_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*36*DATA_W-1:0] tile_in,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          ack,
  output logic                       pool_enable,
  output logic [36*DATA_W-1:0]       pool_tile,
  input  logic                       pool_done,
  input  logic [9*DATA_W-1:0]        pool_result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [2:0]                 result_ch,
  output logic [9*DATA_W-1:0]        result_data,
  output logic                       result_err
);

  localparam int TW = 36 * DATA_W;
  localparam int RW = 9 * DATA_W;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [2:0]        last_q;
  logic [CW-1:0]     cnt_q;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] ack_q;
  logic              en_q;
  logic              vld_q;
  logic [2:0]        ch_q;
  logic [RW-1:0]     data_q;
  logic              err_q;

  logic              any_d;
  logic [2:0]        sel_d;
  int                best_d;
  int                dist_d;

  // Distance from last+1 with wrap; the nearest requester wins.
  always_comb begin
    any_d  = |req;
    sel_d  = '0;
    best_d = NUM_CH;
    dist_d = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      dist_d = k - int'(last_q) - 1;
      if (dist_d < 0) dist_d = dist_d + NUM_CH;
      if (req[k] && dist_d < best_d) begin
        best_d = dist_d;
        sel_d  = 3'(k);
      end
    end
  end

  always_comb begin
    pool_tile = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (idx_q == 3'(k)) pool_tile = tile_in[k*TW +: TW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= 3'(NUM_CH - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_d) begin
            idx_q   <= sel_d;
            last_q  <= sel_d;
            cnt_q   <= '0;
            grant_q <= ONE << sel_d;
            en_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (pool_done) begin
            data_q  <= pool_result;
            ch_q    <= idx_q;
            err_q   <= 1'b0;
            vld_q   <= 1'b1;
            grant_q <= '0;
            en_q    <= 1'b0;
            state_q <= OUT;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            data_q  <= '0;
            ch_q    <= idx_q;
            err_q   <= 1'b1;
            vld_q   <= 1'b1;
            grant_q <= '0;
            en_q    <= 1'b0;
            state_q <= OUT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OUT: begin
          if (result_ready) begin
            vld_q   <= 1'b0;
            ack_q   <= ONE << idx_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign ack          = ack_q;
  assign pool_enable  = en_q;
  assign result_valid = vld_q;
  assign result_ch    = ch_q;
  assign result_data  = data_q;
  assign result_err   = err_q;

endmodule

// File: doc/pool_channel_scheduler.md
# pool_channel_scheduler

Controller that time-shares one `maxPool6x6` engine among `NUM_CH` feature-map channels produced by the convolution stage. It arbitrates round-robin among channels with a 6x6 tile ready and muxes the granted tile onto the engine input. It drives the engine `enable`, waits for `done` with a timeout, and returns the 3x3 pooled result, tagged with its channel, over a valid/ready interface. It sits between the conv output buffers and the pooled-feature buffer.

## Interface
- `NUM_CH`, 4: number of requesting channels (2..8).
- `DATA_W`, 8: element width, unsigned.
- `MAX_WAIT`, 16: enable-high cycles allowed before a timeout is declared.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_CH  level request per channel: tile valid.
- `tile_in`  in  NUM_CH*36*DATA_W  channel k tile at `[k*36*DATA_W +: 36*DATA_W]`; element [r][c] at `((r*6+c)*DATA_W) +: DATA_W`.
- `grant`  out  NUM_CH  one-hot, high while that channel owns the engine.
- `ack`  out  NUM_CH  one-cycle pulse when that channel's result is accepted downstream.
- `pool_enable`  out  1  to engine `enable`.
- `pool_tile`  out  36*DATA_W  granted tile (same packing); all zero when idle.
- `pool_done`  in  1  from engine `done`.
- `pool_result`  in  9*DATA_W  engine output; [r][c] at `((r*3+c)*DATA_W) +: DATA_W`.
- `result_valid`  out  1  result held for downstream.
- `result_ready`  in  1  downstream accepts.
- `result_ch`  out  3  channel index of the result.
- `result_data`  out  9*DATA_W  captured pooled result.
- `result_err`  out  1  result produced by timeout; data forced to zero.

## Operation
- Round-robin pointer `last`; reset value `NUM_CH-1`, so channel 0 has first priority.
- States are IDLE, RUN and OUT.
- IDLE:
  - `req` is sampled only in this state.
  - If any bit is set, select the first set bit searching from `last+1` with wrap-around, then register `idx` and `last <= idx`.
  - Go to RUN.
  - `grant` = 0, `pool_enable` = 0.
- RUN:
  - `grant[idx]` = 1, `pool_enable` = 1, `pool_tile` = `tile_in` slice `idx`.
  - Wait counter starts at 0 on entry and increments each cycle.
  - If `pool_done` is sampled 1: capture `pool_result` into `result_data`, set `result_ch` = `idx`, `result_err` = 0, `result_valid` = 1. Go to OUT.
  - Else if counter == `MAX_WAIT-1`: `result_data` = 0, `result_err` = 1, `result_valid` = 1. Go to OUT.
  - `pool_done` takes priority if it arrives on the timeout cycle.
- OUT:
  - `pool_enable` = 0, `grant` = 0.
  - Result registers hold stable while `result_ready` = 0.
  - On `result_valid && result_ready`: `result_valid` <= 0, pulse `ack[idx]` for one cycle, go to IDLE.
- Requester rule: after `ack`, a channel drops `req` or presents a new tile in the same cycle. Holding `req` with the old tile is a requester error.
- Engine `enable` is low for at least 2 cycles between jobs (OUT + IDLE), which guarantees the engine restarts and clears `done`.
- `req` bits that change during RUN or OUT have no effect until IDLE.

## Timing
- All outputs are registered, except `pool_tile`, which is a combinational mux on registered `idx` and state.
- `req` seen in IDLE at edge N gives `grant` and `pool_enable` high from edge N+1.
- `pool_done` sampled at edge M gives `result_valid` high from edge M+1, and `pool_enable` low from M+1.
- Accept at edge A: `ack` is high during A+1 only. The earliest next grant is at A+2.
- Minimum job period is engine latency + 3 cycles.
- Reset, including mid-RUN or mid-OUT, takes effect at the next edge:
  - All outputs become 0 and the state is IDLE.
  - `last` = `NUM_CH-1` and the counter = 0.
  - An in-flight result is discarded with no `ack`.
- With `req` = 0 the block stays in IDLE indefinitely with all outputs 0.

## Test plan
- **Single channel:** ch0 tile = 1..36 row-major, engine model asserts `done` 5 cycles after enable. Required: `result_data` = {8,10,12,20,22,24,32,34,36}, `result_ch` = 0, `result_err` = 0, `ack` = 4'b0001 for one cycle, `grant` high exactly 6 cycles.
- **Fairness:** all `req` = 4'b1111 after reset, `result_ready` tied 1, requesters re-presenting after each `ack`. Required: grant order 0,1,2,3,0,1; never two grant bits set at once.
- **Backpressure:** `result_ready` = 0 for 5 cycles after `result_valid`, with ch1 still requesting. Required: `result_data`, `result_ch` and `result_valid` stable; `pool_enable` = 0 and `grant` = 0 throughout; ch1 granted 2 cycles after ready rises.
- **Timeout:** engine never asserts `done`. Required: `pool_enable` high exactly 16 cycles, then `result_valid` = 1, `result_err` = 1, `result_data` = 0. A following ch2 job with a working engine returns `result_err` = 0.
- **Tile mux:** ch1 tile all 0x00, ch2 tile all 0xFF, `req` = 4'b0100. Required: `pool_tile` = all 0xFF while `grant` = 4'b0100; `pool_tile` = 0 in IDLE and OUT.
- **Reset mid-RUN:** assert `rst` for one cycle 3 cycles into a ch3 job. Required: next cycle all outputs 0 and no `ack`. After release, `req` = 4'b1001 grants ch0 first.
